// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_BUSY = 2'd1,
    FLUSH   = 2'd2
  } hc_state_e;

  // Wide enough for MC_LATENCY-1 with MC_LATENCY up to 255.
  localparam int MC_CNT_W = 8;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: EX load whose destination feeds the ID instruction.
module load_use_detect (
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       load_use_o
);

  // x0 is hardwired zero, so a load to it never creates a dependency.
  assign load_use_o = ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) & id_valid_i &
                      ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, multi-cycle EX hold.
// Multi-cycle (mul/div) support is present only when HAZARD_MULDIV_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MC_LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        ex_valid_i,
  input  logic        ex_mem_read_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        branch_taken_i,
  input  logic        mc_start_i,
  output logic        pc_stall_o,
  output logic        if_id_stall_o,
  output logic        id_ex_bubble_o,
  output logic        if_id_flush_o,
  output logic        ex_hold_o,
  output logic        mc_done_o,
  output logic [31:0] stall_cycles_o
);

  hc_state_e   state_q, state_d;
  logic        load_use;
  logic        branch_run;
  logic        mc_run;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  load_use_detect u_load_use_detect (
    .ex_valid_i    (ex_valid_i),
    .ex_mem_read_i (ex_mem_read_i),
    .ex_rd_i       (ex_rd_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .load_use_o    (load_use)
  );

  assign branch_run = ex_valid_i & branch_taken_i;

`ifdef HAZARD_MULDIV_EN
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;
  assign mc_run = ex_valid_i & mc_start_i;
`else
  logic unused_mc_start;
  assign unused_mc_start = mc_start_i;
  assign mc_run          = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    pc_stall_o     = 1'b0;
    if_id_stall_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    if_id_flush_o  = 1'b0;
    ex_hold_o      = 1'b0;
    mc_done_o      = 1'b0;
`ifdef HAZARD_MULDIV_EN
    cnt_d          = cnt_q;
`endif
    case (state_q)
      RUN: begin
        if (branch_run) begin
          if_id_flush_o  = 1'b1;
          id_ex_bubble_o = 1'b1;
          state_d        = FLUSH;
        end else if (mc_run) begin
          ex_hold_o      = 1'b1;
          pc_stall_o     = 1'b1;
          if_id_stall_o  = 1'b1;
`ifdef HAZARD_MULDIV_EN
          cnt_d          = MC_CNT_W'(MC_LATENCY - 1);
`endif
          state_d        = MC_BUSY;
        end else if (load_use) begin
          pc_stall_o     = 1'b1;
          if_id_stall_o  = 1'b1;
          id_ex_bubble_o = 1'b1;
        end
      end
      MC_BUSY: begin
`ifdef HAZARD_MULDIV_EN
        if (cnt_q != MC_CNT_W'(1)) begin
          ex_hold_o     = 1'b1;
          pc_stall_o    = 1'b1;
          if_id_stall_o = 1'b1;
          cnt_d         = cnt_q - MC_CNT_W'(1);
        end else begin
          mc_done_o     = 1'b1;
          state_d       = RUN;
        end
`else
        state_d = RUN;
`endif
      end
      FLUSH: begin
        if_id_flush_o = 1'b1;
        state_d       = RUN;
      end
      default: state_d = RUN;
    endcase

    // Outputs are Mealy, so reset must mask them combinationally too.
    if (rst_i) begin
      pc_stall_o     = 1'b0;
      if_id_stall_o  = 1'b0;
      id_ex_bubble_o = 1'b0;
      if_id_flush_o  = 1'b0;
      ex_hold_o      = 1'b0;
      mc_done_o      = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      stall_cnt_q <= 32'd0;
`ifdef HAZARD_MULDIV_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef HAZARD_MULDIV_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MC_LATENCY=4); MC cases follow HAZARD_MULDIV_EN.
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i, id_rs2_i;
  logic        ex_valid_i, ex_mem_read_i;
  logic [4:0]  ex_rd_i;
  logic        branch_taken_i, mc_start_i;
  logic        pc_stall_o, if_id_stall_o, id_ex_bubble_o, if_id_flush_o;
  logic        ex_hold_o, mc_done_o;
  logic [31:0] stall_cycles_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_stall;

  hazard_ctrl #(.MC_LATENCY(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .ex_valid_i     (ex_valid_i),
    .ex_mem_read_i  (ex_mem_read_i),
    .ex_rd_i        (ex_rd_i),
    .branch_taken_i (branch_taken_i),
    .mc_start_i     (mc_start_i),
    .pc_stall_o     (pc_stall_o),
    .if_id_stall_o  (if_id_stall_o),
    .id_ex_bubble_o (id_ex_bubble_o),
    .if_id_flush_o  (if_id_flush_o),
    .ex_hold_o      (ex_hold_o),
    .mc_done_o      (mc_done_o),
    .stall_cycles_o (stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic exv, input logic mr, input logic [4:0] rd,
                        input logic br, input logic mc);
    id_valid_i     = idv;
    id_rs1_i       = rs1;
    id_rs2_i       = rs2;
    ex_valid_i     = exv;
    ex_mem_read_i  = mr;
    ex_rd_i        = rd;
    branch_taken_i = br;
    mc_start_i     = mc;
  endtask

  // Checks the Mealy outputs of the current cycle, then advances the stall model.
  task automatic chk_out(input string tag, input logic ps, input logic is, input logic bb,
                         input logic fl, input logic eh, input logic md);
    chk({tag, ".pc_stall"},  {31'd0, pc_stall_o},     {31'd0, ps});
    chk({tag, ".ifid_stall"}, {31'd0, if_id_stall_o}, {31'd0, is});
    chk({tag, ".bubble"},    {31'd0, id_ex_bubble_o}, {31'd0, bb});
    chk({tag, ".flush"},     {31'd0, if_id_flush_o},  {31'd0, fl});
    chk({tag, ".ex_hold"},   {31'd0, ex_hold_o},      {31'd0, eh});
    chk({tag, ".mc_done"},   {31'd0, mc_done_o},      {31'd0, md});
    chk({tag, ".stall_cnt"}, stall_cycles_o,          exp_stall);
    if (ps && !rst_i && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
  endtask

  task automatic step(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic exv, input logic mr, input logic [4:0] rd,
                      input logic br, input logic mc);
    @(negedge clk_i);
    set_in(idv, rs1, rs2, exv, mr, rd, br, mc);
    #2;
  endtask

  initial begin
    // Reset with hazards present on the inputs: everything must stay quiet.
    rst_i = 1'b1;
    exp_stall = 32'd0;
    set_in(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
    #2;
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b0;

    // Load x5 in EX, rs1=x5 in ID.
    step(1, 5'd5, 5'd1, 1, 1, 5'd5, 0, 0); chk_out("lu_rs1", 1, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);          chk_out("lu_after", 0, 0, 0, 0, 0, 0);
    // Load to x0 matching rs2=x0 must not stall.
    step(1, 5'd3, 5'd0, 1, 1, 5'd0, 0, 0); chk_out("lu_x0", 0, 0, 0, 0, 0, 0);
    // Match on rs2.
    step(1, 5'd2, 5'd7, 1, 1, 5'd7, 0, 0); chk_out("lu_rs2", 1, 1, 1, 0, 0, 0);
    // Not a load, or EX invalid: no stall.
    step(1, 5'd7, 5'd7, 1, 0, 5'd7, 0, 0); chk_out("no_load", 0, 0, 0, 0, 0, 0);
    step(1, 5'd7, 5'd7, 0, 1, 5'd7, 0, 0); chk_out("ex_inv", 0, 0, 0, 0, 0, 0);

    // Taken branch wins over load-use, then one FLUSH cycle, then RUN.
    step(1, 5'd5, 5'd1, 1, 1, 5'd5, 1, 0); chk_out("br_T", 0, 0, 1, 1, 0, 0);
    step(1, 5'd5, 5'd1, 1, 1, 5'd5, 0, 0); chk_out("br_T1", 0, 0, 0, 1, 0, 0);
    step(1, 5'd5, 5'd1, 1, 1, 5'd5, 0, 0); chk_out("br_T2", 1, 1, 1, 0, 0, 0);

`ifdef HAZARD_MULDIV_EN
    // Multi-cycle op, latency 4; branch at T+1 ignored.
    step(0, 0, 0, 1, 0, 5'd9, 0, 1);       chk_out("mc_T", 1, 1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 1, 0);          chk_out("mc_T1", 1, 1, 0, 0, 1, 0);
    step(1, 5'd5, 0, 1, 1, 5'd5, 0, 0);    chk_out("mc_T2", 1, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);          chk_out("mc_T3", 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);          chk_out("mc_T4", 0, 0, 0, 0, 0, 0);

    // Reset at T+1 of an op aborts it.
    step(0, 0, 0, 1, 0, 5'd9, 0, 1);       chk_out("mcr_T", 1, 1, 0, 0, 1, 0);
    @(negedge clk_i);
    set_in(0, 0, 0, 1, 0, 0, 1, 1);
    rst_i = 1'b1;
    exp_stall = 32'd0;
    #2;
    chk_out("mcr_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);        chk_out("mcr_post", 0, 0, 0, 0, 0, 0);
    end
`else
    // Without multi-cycle support mc_start_i has no effect.
    step(0, 0, 0, 1, 0, 5'd9, 0, 1);       chk_out("mc_off_T", 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);          chk_out("mc_off_T1", 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);          chk_out("mc_off_T2", 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);          chk_out("mc_off_T3", 0, 0, 0, 0, 0, 0);
`endif

    // Reset during FLUSH: no leftover flush after release.
    step(0, 0, 0, 1, 0, 0, 1, 0);          chk_out("flr_T", 0, 0, 1, 1, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    exp_stall = 32'd0;
    #2;
    chk_out("flr_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0);          chk_out("flr_post", 0, 0, 0, 0, 0, 0);

    // Stall counter saturation.
    @(negedge clk_i);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    exp_stall = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      step(1, 5'd5, 0, 1, 1, 5'd5, 0, 0);  chk_out("sat", 1, 1, 1, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);          chk_out("sat_end", 0, 0, 0, 0, 0, 0);
    chk("sat_value", stall_cycles_o, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
